// File: rtl/approx_adder_gear_seq.sv
// GeAr approximate adder/subtractor with optional iterative carry correction.
// Optional feature: define GEAR_CORRECTION_EN to build the CORRECT state and cin registers.
// Ports: clk, rst_n (async active-low), in_valid/in_ready, a, b, sub, correct,
//        out_valid/out_ready, result, err_detected, corr_count.
module approx_adder_gear_seq #(
  parameter int N = 32,
  parameter int R = 2,
  parameter int P = 6,
  localparam int L = R + P,
  localparam int K = (N - L) / R + 1,
  localparam int CW = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic          sub,
  input  logic          correct,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  result,
  output logic          err_detected,
  output logic [CW-1:0] corr_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
`ifdef GEAR_CORRECTION_EN
  localparam logic [1:0] S_CORRECT = 2'd1;
`endif
  localparam logic [1:0] S_DONE    = 2'd2;

  // ci[0] is the carry-in of window 0 (the subtract bit);
  // ci[i], i>=1, is the carry-in of window i.
  function automatic logic [N-1:0] gear_res(
    input logic [N-1:0] av,
    input logic [N-1:0] bv,
    input logic [K-1:0] ci
  );
    logic [N-1:0] res;
    logic [L:0]   w;
    res = '0;
    for (int i = 0; i < K; i++) begin
      w = {1'b0, av[i*R +: L]} + {1'b0, bv[i*R +: L]}
        + {{L{1'b0}}, ci[i]};
      if (i == 0) res[L-1:0] = w[L-1:0];
      else        res[i*R+P +: R] = w[L-1:P];
    end
    return res;
  endfunction

  // err[i]: carry into bit iR+P seen by window i differs from
  // the carry-out of window i-1 (which ends at that same bit).
  function automatic logic [K-1:0] gear_err(
    input logic [N-1:0] av,
    input logic [N-1:0] bv,
    input logic [K-1:0] ci
  );
    logic [K-1:0] e;
    logic [L:0]   w;
    logic [P:0]   lp;
    logic         co_prev;
    e = '0;
    co_prev = 1'b0;
    for (int i = 0; i < K; i++) begin
      w = {1'b0, av[i*R +: L]} + {1'b0, bv[i*R +: L]}
        + {{L{1'b0}}, ci[i]};
      lp = {1'b0, av[i*R +: P]} + {1'b0, bv[i*R +: P]}
         + {{P{1'b0}}, ci[i]};
      if (i > 0) e[i] = lp[P] ^ co_prev;
      co_prev = w[L];
    end
    return e;
  endfunction

`ifdef GEAR_CORRECTION_EN
  // fix[i]: carry into bit iR as computed inside window i-1,
  // i.e. the better-informed carry-in for window i.
  function automatic logic [K-1:0] gear_fix(
    input logic [N-1:0] av,
    input logic [N-1:0] bv,
    input logic [K-1:0] ci
  );
    logic [K-1:0] f;
    logic [R:0]   lr;
    logic         cr_prev;
    f = '0;
    cr_prev = 1'b0;
    for (int i = 0; i < K; i++) begin
      lr = {1'b0, av[i*R +: R]} + {1'b0, bv[i*R +: R]}
         + {{R{1'b0}}, ci[i]};
      if (i > 0) f[i] = cr_prev;
      cr_prev = lr[R];
    end
    return f;
  endfunction
`endif

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  bv_q, bv_d;
  logic          sub_q, sub_d;
  logic          err_q, err_d;

  logic [N-1:0]  bv_in;
  logic [K-1:0]  err_in;
  logic [K-1:0]  cin_cur;
  logic [CW-1:0] cnt_cur;

  assign bv_in  = sub ? ~b : b;
  assign err_in = gear_err(a, bv_in, {{(K-1){1'b0}}, sub});

`ifdef GEAR_CORRECTION_EN
  logic [K-1:1]  cin_q, cin_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [K-1:0]  err_c;
  logic [K-1:0]  fix_c;
  logic [K-1:1]  cin_n;
  logic [K-1:0]  err_n;
  logic          found;

  assign cin_cur = {cin_q, sub_q};
  assign cnt_cur = cnt_q;
  assign err_c   = gear_err(a_q, bv_q, cin_cur);
  assign fix_c   = gear_fix(a_q, bv_q, cin_cur);

  // One correction step: repair only the lowest erroneous window.
  always_comb begin
    found = 1'b0;
    cin_n = cin_q;
    for (int i = 1; i < K; i++) begin
      if (!found && err_c[i]) begin
        found    = 1'b1;
        cin_n[i] = fix_c[i];
      end
    end
  end

  // Errors after the step decide whether this is the last one.
  assign err_n = gear_err(a_q, bv_q, {cin_n, sub_q});
`else
  logic unused_ok;
  assign cin_cur   = {{(K-1){1'b0}}, sub_q};
  assign cnt_cur   = '0;
  assign unused_ok = correct;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    bv_d    = bv_q;
    sub_d   = sub_q;
    err_d   = err_q;
`ifdef GEAR_CORRECTION_EN
    cin_d   = cin_q;
    cnt_d   = cnt_q;
`endif
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (in_valid) begin
          a_d   = a;
          bv_d  = bv_in;
          sub_d = sub;
          err_d = |err_in;
`ifdef GEAR_CORRECTION_EN
          cin_d = '0;
          cnt_d = '0;
          state_d = (correct && |err_in) ? S_CORRECT : S_DONE;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef GEAR_CORRECTION_EN
      state_q == S_CORRECT: begin
        cin_d = cin_n;
        cnt_d = cnt_q + CW'(1);
        if (err_n == '0) state_d = S_DONE;
      end
`endif
      state_q == S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      bv_q    <= '0;
      sub_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef GEAR_CORRECTION_EN
      cin_q   <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      bv_q    <= bv_d;
      sub_q   <= sub_d;
      err_q   <= err_d;
`ifdef GEAR_CORRECTION_EN
      cin_q   <= cin_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign result       = gear_res(a_q, bv_q, cin_cur);
  assign err_detected = err_q;
  assign corr_count   = cnt_cur;

endmodule

// File: tb/tb_approx_adder_gear_seq.sv
// Directed bench for approx_adder_gear_seq (N=32, R=2, P=6, K=13).
// Expectations follow GEAR_CORRECTION_EN when it is defined.
module tb_approx_adder_gear_seq;

`ifdef GEAR_CORRECTION_EN
  localparam bit CORR_EN = 1'b1;
`else
  localparam bit CORR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        sub_i;
  logic        corr_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        err_detected;
  logic [3:0]  corr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  approx_adder_gear_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a_i),
    .b            (b_i),
    .sub          (sub_i),
    .correct      (corr_i),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .err_detected (err_detected),
    .corr_count   (corr_count)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [31:0] av,
                        input logic [31:0] bv,
                        input logic sb,
                        input logic cr,
                        input logic [31:0] exp_res,
                        input logic exp_err,
                        input int exp_cnt);
    int  lat;
    bit  seen;
    @(negedge clk);
    check({tag, ".rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a_i = av; b_i = bv; sub_i = sb; corr_i = cr;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1'b1;
    end
    check({tag, ".lat"}, 32'(lat), 32'(1 + exp_cnt));
    check({tag, ".res"}, result, exp_res);
    check({tag, ".err"}, 32'(err_detected), 32'(exp_err));
    check({tag, ".cnt"}, 32'(corr_count), 32'(exp_cnt));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, ".drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    a_i = '0; b_i = '0; sub_i = 1'b0; corr_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.rdy", 32'(in_ready), 32'd1);
    check("rst.vld", 32'(out_valid), 32'd0);
    check("rst.res", result, 32'd0);
    check("rst.err", 32'(err_detected), 32'd0);
    check("rst.cnt", 32'(corr_count), 32'd0);
    rst_n = 1'b1;

    run_op("add53", 32'd5, 32'd3, 1'b0, 1'b1, 32'd8, 1'b0, 0);
    run_op("ffnc", 32'hFF, 32'd1, 1'b0, 1'b0, 32'h0, 1'b1, 0);
    run_op("ffc", 32'hFF, 32'd1, 1'b0, 1'b1,
           CORR_EN ? 32'h100 : 32'h0, 1'b1, CORR_EN ? 1 : 0);
    run_op("subc", 32'd10, 32'd3, 1'b1, 1'b1,
           CORR_EN ? 32'h7 : 32'hFFFFFC07, 1'b1, CORR_EN ? 11 : 0);
    run_op("subnc", 32'd10, 32'd3, 1'b1, 1'b0,
           32'hFFFFFC07, 1'b1, 0);
    run_op("nocy", 32'h12345678, 32'h01010101, 1'b0, 1'b1,
           32'h13355779, 1'b0, 0);
    run_op("subff", 32'hFFFFFFFF, 32'd1, 1'b1, 1'b1,
           32'hFFFFFFFE, 1'b0, 0);
    run_op("wrap", 32'h80000000, 32'h80000000, 1'b0, 1'b1,
           32'h0, 1'b0, 0);

    // backpressure: new request held on in_valid while DONE stalls
    @(negedge clk);
    in_valid = 1'b1;
    a_i = 32'd5; b_i = 32'd3; sub_i = 1'b0; corr_i = 1'b1;
    @(posedge clk);
    #1 a_i = 32'h12345678; b_i = 32'h01010101;
    @(negedge clk);
    check("bp.vld0", 32'(out_valid), 32'd1);
    check("bp.res0", result, 32'd8);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp.res%0d", c + 1), result, 32'd8);
      check($sformatf("bp.rdy%0d", c + 1), 32'(in_ready), 32'd0);
      check($sformatf("bp.vld%0d", c + 1), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp.idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp.vld2", 32'(out_valid), 32'd1);
    check("bp.res2", result, 32'h13355779);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    // reset in the middle of an operation aborts it
    @(negedge clk);
    in_valid = 1'b1;
    a_i = 32'd10; b_i = 32'd3; sub_i = 1'b1; corr_i = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
`ifdef GEAR_CORRECTION_EN
    repeat (4) @(negedge clk);
    check("abort.mid", 32'(corr_count), 32'd3);
`else
    @(negedge clk);
    check("abort.mid", 32'(out_valid), 32'd1);
`endif
    rst_n = 1'b0;
    #1;
    check("abort.rdy", 32'(in_ready), 32'd1);
    check("abort.vld", 32'(out_valid), 32'd0);
    check("abort.res", result, 32'd0);
    check("abort.err", 32'(err_detected), 32'd0);
    check("abort.cnt", 32'(corr_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    check("abort.noval", 32'(saw), 32'd0);
    run_op("post", 32'd5, 32'd3, 1'b0, 1'b1, 32'd8, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/approx_adder_gear_seq.md
APPROX_ADDER_GEAR_SEQ -- requirements
Module: approx_adder_gear_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL clear immediately when reset is low.
REQ-002 Parameter N, default 32: operand and result width.
REQ-003 Parameter R, default 2: result bits produced by each sub-adder.
REQ-004 Parameter P, default 6: carry-prediction bits per sub-adder. L=R+P; K=(N-L)/R+1 sub-adders; (N-L) mod R SHALL be 0.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  operand request.
REQ-008 in_ready  out  1  block can accept a request.
REQ-009 a, b  in  N  operands.
REQ-010 sub  in  1  1=a-b (b inverted, carry-in 1 into sub-adder 0); 0=a+b.
REQ-011 correct  in  1  request iterative error correction.
REQ-012 out_valid  out  1  result available.
REQ-013 out_ready  in  1  consumer accepts result.
REQ-014 result  out  N  sum/difference.
REQ-015 err_detected  out  1  initial approximate result had at least one sub-adder error.
REQ-016 corr_count  out  clog2(K)  number of correction cycles spent.

Function
REQ-017 Sub-adder 0 SHALL add bits [L-1:0] and drive result[L-1:0]; sub-adder i>=1 SHALL add bits [iR+L-1:iR] with carry-in cin_i (initially 0) and drive only result[iR+L-1:iR+P].
REQ-018 error_i (i>=1) SHALL be 1 when the carry into bit iR+P inside window i differs from the carry-out of window i-1.
REQ-019 A correction step SHALL select the lowest i with error_i=1 and set cin_i to the carry into bit iR inside window i-1.
REQ-020 FSM states: IDLE, CORRECT, DONE; in_ready=1 only in IDLE.
REQ-021 IDLE: on in_valid, register a, b, sub and correct, clear all cin_i and corr_count, and latch err_detected from the initial error_i vector.
REQ-022 The acceptance edge SHALL move the FSM to CORRECT if correction is enabled, correct=1 and any error_i=1; otherwise to DONE.
REQ-023 CORRECT: each cycle SHALL perform one correction step and increment corr_count; when no error_i remains, the next state SHALL be DONE.
REQ-024 At most K-1 correction cycles SHALL occur, and the final result SHALL equal the exact N-bit (a±b) mod 2^N.
REQ-025 DONE: out_valid=1, and result, err_detected and corr_count SHALL be held stable until out_ready=1, which returns the FSM to IDLE on that edge.
REQ-026 Latency SHALL be 1 cycle from acceptance to out_valid with no correction, and 1+corr_count cycles with correction.
REQ-027 in_valid while the FSM is not in IDLE SHALL be ignored; no result SHALL be lost or overwritten under out_ready backpressure.
REQ-028 Carry-out beyond bit N-1 SHALL be discarded.

Reset
REQ-029 Reset SHALL force IDLE, in_ready=1, out_valid=0, result=0, err_detected=0, corr_count=0, and all cin_i=0.
REQ-030 Reset asserted in CORRECT or DONE SHALL abort the operation; no out_valid SHALL follow for the aborted request.

Configuration
REQ-031 Macro GEAR_CORRECTION_EN defined: the CORRECT state and cin_i registers SHALL be present as specified.
REQ-032 GEAR_CORRECTION_EN undefined: the correct input SHALL be ignored, the FSM SHALL go IDLE->DONE only, corr_count SHALL be tied to 0, and err_detected SHALL still be reported.

Verification (N=32, R=2, P=6, so K=13)
REQ-033 Add without error: a=5, b=3, correct=1 -> result=8, err_detected=0, corr_count=0, out_valid one cycle after acceptance.
REQ-034 Add with error, no correction: a=0x000000FF, b=1, correct=0 -> result=0x00000000, err_detected=1, corr_count=0.
REQ-035 Add with correction (macro defined): a=0x000000FF, b=1, correct=1 -> result=0x00000100, err_detected=1, corr_count=1, out_valid two cycles after acceptance.
REQ-036 Subtract with correction: a=10, b=3, sub=1, correct=1 -> result=0x00000007, err_detected=1, corr_count=11; with correct=0 -> result=0xFFFFFC07.
REQ-037 Backpressure: out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands -> result held, in_ready=0, and the second request is accepted only after out_ready=1.
REQ-038 Reset low during CORRECT (case REQ-036 at correction cycle 4) -> immediate IDLE with all outputs at reset values and no out_valid; a following a=5, b=3 request -> 8.
